// File: rtl/gerador_pulso_saida_pkg.sv
// Shared types and helpers for the timed output pulse generator and other timed blocks.
package gerador_pulso_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ATIVO  = 2'd1,
        GUARDA = 2'd2
    } estado_pulso_t;

    function automatic int unsigned ms_para_ciclos(input int unsigned freq_hz,
                                                   input int unsigned ms);
        return (freq_hz / 32'd1000) * ms;
    endfunction

endpackage

// File: rtl/gerador_pulso_saida_if.sv
// Trigger/output bundle between the control FSM (master) and the pulse generator (slave).
interface gerador_pulso_saida_if #(
    parameter int unsigned MAX_PENDENTES = 3
) ();
    localparam int unsigned PW = $clog2(MAX_PENDENTES + 1);

    logic          pulso_entrada;
    logic          sinal_saida;
    logic          ocupado;
    logic          descartado;
    logic [PW-1:0] pendentes;

    modport master (
        output pulso_entrada,
        input  sinal_saida,
        input  ocupado,
        input  descartado,
        input  pendentes
    );

    modport slave (
        input  pulso_entrada,
        output sinal_saida,
        output ocupado,
        output descartado,
        output pendentes
    );
endinterface

// File: rtl/gerador_pulso_saida_temporizador_ciclos.sv
// Loadable down-counter; fim is a registered flag that is high while the count is 0.
module temporizador_ciclos #(
    parameter int unsigned LARGURA = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               carga,
    input  logic [LARGURA-1:0] valor,
    output logic               fim
);
    logic [LARGURA-1:0] contador;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contador <= '0;
            fim      <= 1'b1;
        end else if (carga) begin
            contador <= valor;
            fim      <= (valor == '0);
        end else if (contador != '0) begin
            contador <= contador - LARGURA'(1);
            fim      <= (contador == LARGURA'(1));
        end
    end
endmodule

// File: rtl/gerador_pulso_saida.sv
// Turns trigger pulses into a fixed on-time level followed by a guard time.
// Optional trigger queue enabled by defining GERADOR_PULSO_FILA_EN.
module gerador_pulso_saida
    import gerador_pulso_pkg::*;
#(
    parameter int unsigned FREQ_CLK_HZ   = 25_000_000,
    parameter int unsigned TEMPO_ON_MS   = 100,
    parameter int unsigned TEMPO_OFF_MS  = 50,
    parameter int unsigned MAX_PENDENTES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gerador_pulso_saida_if.slave  bus
);
    localparam int unsigned ON_CICLOS  = ms_para_ciclos(FREQ_CLK_HZ, TEMPO_ON_MS);
    localparam int unsigned OFF_CICLOS = ms_para_ciclos(FREQ_CLK_HZ, TEMPO_OFF_MS);
    localparam int unsigned MAX_CICLOS = (ON_CICLOS > OFF_CICLOS) ? ON_CICLOS : OFF_CICLOS;
    localparam int unsigned CW = $clog2(MAX_CICLOS + 1);
    localparam int unsigned PW = $clog2(MAX_PENDENTES + 1);
    localparam logic [CW-1:0] ON_RECARGA  = CW'(ON_CICLOS - 1);
    localparam logic [CW-1:0] OFF_RECARGA = CW'(OFF_CICLOS - 1);

    estado_pulso_t estado;
    logic [PW-1:0] pendentes_q;
    logic          sinal_q, ocupado_q, descartado_q;
    logic          gatilho, carga, fim, enfileirar, fila_cheia;
    logic [CW-1:0] valor;

    temporizador_ciclos #(.LARGURA(CW)) u_temporizador (
        .clk   (clk),
        .rst_n (rst_n),
        .carga (carga),
        .valor (valor),
        .fim   (fim)
    );

    // The final GUARDA cycle never queues: its trigger starts the next pulse directly.
    always_comb begin
        gatilho    = bus.pulso_entrada;
        carga      = 1'b0;
        valor      = ON_RECARGA;
        enfileirar = gatilho && ((estado == ATIVO) || (estado == GUARDA && !fim));
        case (estado)
            OCIOSO:  carga = gatilho;
            ATIVO: begin
                carga = fim;
                valor = OFF_RECARGA;
            end
            GUARDA:  carga = fim && ((pendentes_q != '0) || gatilho);
            default: carga = 1'b0;
        endcase
`ifdef GERADOR_PULSO_FILA_EN
        fila_cheia = (pendentes_q == PW'(MAX_PENDENTES));
`else
        fila_cheia = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado       <= OCIOSO;
            pendentes_q  <= '0;
            sinal_q      <= 1'b0;
            ocupado_q    <= 1'b0;
            descartado_q <= 1'b0;
        end else begin
            descartado_q <= 1'b0;
            if (enfileirar) begin
                if (fila_cheia) descartado_q <= 1'b1;
                else            pendentes_q  <= pendentes_q + PW'(1);
            end
            case (estado)
                OCIOSO: if (gatilho) begin
                    estado    <= ATIVO;
                    sinal_q   <= 1'b1;
                    ocupado_q <= 1'b1;
                end
                ATIVO: if (fim) begin
                    estado  <= GUARDA;
                    sinal_q <= 1'b0;
                end
                GUARDA: if (fim) begin
                    if ((pendentes_q != '0) || gatilho) begin
                        estado  <= ATIVO;
                        sinal_q <= 1'b1;
                        // A trigger here replaces the queued entry it would consume.
                        if (!gatilho) pendentes_q <= pendentes_q - PW'(1);
                    end else begin
                        estado    <= OCIOSO;
                        ocupado_q <= 1'b0;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    assign bus.sinal_saida = sinal_q;
    assign bus.ocupado     = ocupado_q;
    assign bus.descartado  = descartado_q;
    assign bus.pendentes   = pendentes_q;
endmodule

// File: tb/tb_gerador_pulso_saida.sv
// Directed bench for gerador_pulso_saida: 1 kHz clock, 4-cycle on, 2-cycle guard, queue depth 2.
module tb_gerador_pulso_saida;
    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    gerador_pulso_saida_if #(.MAX_PENDENTES(2)) bus ();

    gerador_pulso_saida #(
        .FREQ_CLK_HZ   (1000),
        .TEMPO_ON_MS   (4),
        .TEMPO_OFF_MS  (2),
        .MAX_PENDENTES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rng(input int unsigned lo, input int unsigned hi);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] pen(input logic [63:0] v, input int unsigned lo,
                                        input int unsigned hi, input logic [1:0] val);
        logic [63:0] r;
        r = v;
        for (int unsigned i = lo; i <= hi; i++) r[2*i +: 2] = val;
        return r;
    endfunction

    task automatic chk(input string tag, input int c, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: got %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    // Reset, then drive trig[c] during cycle c and compare all outputs for cycles 0..last.
    task automatic run(input string nome, input logic [31:0] trig, input int last,
                       input logic [31:0] e_sin, input logic [31:0] e_ocu,
                       input logic [31:0] e_des, input logic [63:0] e_pen);
        rst_n = 1'b0;
        bus.pulso_entrada = 1'b0;
        #1;
        chk({nome, "/rst_sinal"}, -1, {3'b0, bus.sinal_saida}, 4'd0);
        chk({nome, "/rst_ocupado"}, -1, {3'b0, bus.ocupado}, 4'd0);
        chk({nome, "/rst_descartado"}, -1, {3'b0, bus.descartado}, 4'd0);
        chk({nome, "/rst_pendentes"}, -1, {2'b0, bus.pendentes}, 4'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c <= last; c++) begin
            bus.pulso_entrada = trig[c];
            chk({nome, "/sinal_saida"}, c, {3'b0, bus.sinal_saida}, {3'b0, e_sin[c]});
            chk({nome, "/ocupado"}, c, {3'b0, bus.ocupado}, {3'b0, e_ocu[c]});
            chk({nome, "/descartado"}, c, {3'b0, bus.descartado}, {3'b0, e_des[c]});
            chk({nome, "/pendentes"}, c, {2'b0, bus.pendentes}, {2'b0, e_pen[2*c +: 2]});
            if (c < last) begin
                @(posedge clk); #1;
            end
        end
        bus.pulso_entrada = 1'b0;
    endtask

    initial begin
        logic [31:0] tres;
        logic [63:0] p;
        rst_n = 1'b0;
        bus.pulso_entrada = 1'b0;
        tres = rng(11, 14) | rng(17, 20) | rng(23, 26);

        run("single", rng(10, 10), 31, rng(11, 14), rng(11, 16), '0, '0);

`ifdef GERADOR_PULSO_FILA_EN
        p = pen(pen(pen('0, 13, 13, 2'd1), 14, 16, 2'd2), 17, 22, 2'd1);
        run("t10_12_13", rng(10, 10) | rng(12, 13), 31, tres, rng(11, 28), '0, p);

        p = pen(pen(pen('0, 12, 12, 2'd1), 13, 16, 2'd2), 17, 22, 2'd1);
        run("t10_13_drop", rng(10, 13), 31, tres, rng(11, 28), rng(14, 14), p);

        run("held6", rng(10, 15), 31, tres, rng(11, 28), rng(14, 16), p);

        run("rst_mid", rng(10, 11), 12, rng(11, 12), rng(11, 12), '0, pen('0, 12, 12, 2'd1));
`else
        run("t10_12_13", rng(10, 10) | rng(12, 13), 31, rng(11, 14), rng(11, 16), rng(13, 14), '0);

        run("t10_13_drop", rng(10, 13), 31, rng(11, 14), rng(11, 16), rng(12, 14), '0);

        run("held6", rng(10, 15), 31, rng(11, 14), rng(11, 16), rng(12, 16), '0);

        run("rst_mid", rng(10, 11), 12, rng(11, 12), rng(11, 12), rng(12, 12), '0);
`endif
        // Asynchronous reset in mid-pulse must clear outputs before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid/async_sinal", 12, {3'b0, bus.sinal_saida}, 4'd0);
        chk("rst_mid/async_ocupado", 12, {3'b0, bus.ocupado}, 4'd0);
        chk("rst_mid/async_pendentes", 12, {2'b0, bus.pendentes}, 4'd0);
        chk("rst_mid/async_descartado", 12, {3'b0, bus.descartado}, 4'd0);
        @(posedge clk); #1;

        run("after_rst", rng(10, 10), 20, rng(11, 14), rng(11, 16), '0, '0);

        run("final_guard", rng(10, 10) | rng(16, 16), 31, rng(11, 14) | rng(17, 20),
            rng(11, 22), '0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gerador_pulso_saida.md
# gerador_pulso_saida

Output-side counterpart of the input debouncer: converts single-cycle trigger pulses from internal logic into a clean, timed level on an output pin such as an LED, buzzer or relay. Each accepted trigger drives `sinal_saida` high for a fixed on-time, then holds it low for a fixed guard time, so the external device never sees glitches or runt pulses. It sits between the control FSM and the pin driver.

## Interface
- `FREQ_CLK_HZ`, 25_000_000, clock frequency in Hz
- `TEMPO_ON_MS`, 100, output high time in ms (≥1)
- `TEMPO_OFF_MS`, 50, minimum low guard time in ms after each pulse (≥1)
- `MAX_PENDENTES`, 3, queued-trigger capacity (≥1; used only with queue enabled)
- `clk` in 1: system clock, rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `pulso_entrada` in 1: trigger, one-cycle pulse; a level held high counts as one trigger per cycle
- `sinal_saida` out 1: registered clean output to pin
- `ocupado` out 1: high whenever state ≠ OCIOSO
- `descartado` out 1: one-cycle pulse when a trigger is dropped
- `pendentes` out $clog2(MAX_PENDENTES+1): current queued-trigger count (constant 0 without queue)

## Operation
- Derived constants: ON_CICLOS = (FREQ_CLK_HZ/1000)*TEMPO_ON_MS; OFF_CICLOS likewise. Counter width = $clog2(max(ON_CICLOS,OFF_CICLOS)+1).
- States: OCIOSO, ATIVO, GUARDA.
- OCIOSO: a trigger moves the block to ATIVO and loads counter ← ON_CICLOS-1.
- ATIVO: `sinal_saida`=1. The counter decrements. At 0 the block moves to GUARDA and loads OFF_CICLOS-1.
- GUARDA: `sinal_saida`=0. The counter decrements. At 0:
  - if `pendentes`>0 or `pulso_entrada`=1, go to ATIVO and reload ON_CICLOS-1;
  - otherwise go to OCIOSO.
- Trigger in ATIVO/GUARDA, except the final GUARDA cycle, with the queue enabled: `pendentes`+1. If `pendentes`==MAX_PENDENTES, the trigger is dropped instead and `descartado` pulses.
- Final GUARDA cycle with a trigger and `pendentes`>0: one entry is consumed and one added, so the count is unchanged.
- Final GUARDA cycle with a trigger and `pendentes`==0: the trigger is consumed directly and the count stays 0.
- `pendentes` never wraps; it saturates at MAX_PENDENTES.
- Reset: state OCIOSO, counter 0, `sinal_saida`=0, `ocupado`=0, `descartado`=0, `pendentes`=0.
- Reset asserted mid-pulse forces the output low immediately, and all queued triggers are lost.

## Timing
- Trigger sampled in OCIOSO at cycle T → `sinal_saida` high cycles T+1 … T+ON_CICLOS inclusive, then low for at least OFF_CICLOS cycles.
- `ocupado` rises at T+1 together with `sinal_saida`. It falls the cycle after the last GUARDA cycle, and only if no pulse follows.
- Back-to-back queued pulses: exactly OFF_CICLOS low cycles between consecutive high periods.
- `descartado` asserts the cycle after the dropped trigger and is high for exactly 1 cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `GERADOR_PULSO_FILA_EN`.
- Defined: queue active as described above.
- Undefined: `pendentes` is tied to 0. Every trigger outside OCIOSO is dropped with a `descartado` pulse, except a trigger in the final GUARDA cycle, which is accepted and goes straight to ATIVO.

## Structure
- Package `gerador_pulso_pkg`:
  - enum `estado_pulso_t` {OCIOSO, ATIVO, GUARDA};
  - function `ms_para_ciclos(freq_hz, ms)`, shared with other timed blocks.
- Sub-module `temporizador_ciclos`: loadable down-counter with a `carga`/`valor` input and a registered `fim` output when the count reaches 0. It is parameterized by width.
- Top level holds the FSM, the pending counter and the output registers.

## Test plan
All scenarios use FREQ_CLK_HZ=1000, TEMPO_ON_MS=4, TEMPO_OFF_MS=2, MAX_PENDENTES=2, with the queue enabled unless stated.
- Single trigger at cycle 10 → `sinal_saida` high on cycles 11–14, low on 15–16, `ocupado` falls at 17. `pendentes` stays 0.
- Triggers at cycles 10, 12, 13 → high 11–14, low 15–16, high 17–20, low 21–22, high 23–26. `pendentes` peaks at 2.
- Triggers at cycles 10, 11, 12, 13 → 4th trigger dropped, `descartado` high at cycle 14 only. Total of 3 high periods.
- Trigger at cycle 16 (final GUARDA cycle) after a trigger at 10 → high resumes at 17 and `pendentes` stays 0. Repeat without `GERADOR_PULSO_FILA_EN`: same result. Also without the macro, a trigger at 12 raises `descartado` at 13 and produces no second pulse.
- `rst_n` low at cycle 12 mid-pulse with `pendentes`=1 → `sinal_saida`, `ocupado` and `pendentes` are 0 immediately. After release, a new trigger gives a full 4-cycle pulse.
- `pulso_entrada` held high for 6 cycles from cycle 10 → first cycle starts the pulse, next 2 are queued, remaining 3 are dropped. `descartado` is high for 3 consecutive cycles.
